// File: rtl/uart_challenge_host.sv
// Host end of the challenge/response UART link: sends a challenge as 8N1 bytes, then collects the response.
// Latency: tx start bit 1 cycle after an accepted start; result_valid/frame_err 1 cycle after the stop-bit sample.
// Backpressure: none; start is only sampled while idle and dropped while busy (no queueing).
//
// Ports: clk, rst (sync, active-low), start/challenge (request), busy, tx (serial out),
//        rx (serial in, async), result/result_valid, frame_err, timeout.
// Optional feature macro: RESP_TIMEOUT_EN enables the WAIT_RESP watchdog; otherwise timeout is tied low.
module uart_challenge_host #(
   parameter int frequency_clk_ref = 100,
   parameter int baud_rate         = 115200,
   parameter int Challenge_Bit     = 8,
   parameter int bit_cnt           = 29,
   parameter int TIMEOUT_CYCLES    = 10000000
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [Challenge_Bit-1:0] challenge,
   output logic                     busy,
   output logic                     tx,
   input  logic                     rx,
   output logic [bit_cnt-1:0]       result,
   output logic                     result_valid,
   output logic                     frame_err,
   output logic                     timeout
);

   localparam int BAUD_DIV = frequency_clk_ref * 1000000 / baud_rate;
   localparam int CB_BYTES = (Challenge_Bit + 7) / 8;
   localparam int RB_BYTES = (bit_cnt + 7) / 8;
   localparam int CHW      = 8 * CB_BYTES;
   localparam int BW       = $clog2(BAUD_DIV);
   localparam int CBW      = $clog2(CB_BYTES + 1);
   localparam int RBW      = $clog2(RB_BYTES + 1);

   // Elaboration-time guard against unusable configurations.
   if (BAUD_DIV < 4 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
      $error("uart_challenge_host: BAUD_DIV must be >= 4 and TIMEOUT_CYCLES >= 1");
   end

   // DONE's work (load result, pulse result_valid) is folded into the stop-bit
   // sample edge so the pulse lands exactly one cycle after that sample.
   typedef enum logic [1:0] {IDLE, TX_CHAL, WAIT_RESP, RX_BYTE} state_t;

   state_t             state_q;
   logic [CHW-1:0]     chal_q;
   logic [BW-1:0]      baud_q;
   logic [3:0]         bit_q;
   logic [CBW-1:0]     tx_byte_q;
   logic [RBW-1:0]     rx_byte_q;
   logic [7:0]         shreg_q;
   logic [bit_cnt-1:0] acc_q;
   logic               rx_s1_q, rx_s2_q, rx_prev_q;
   logic               tx_q, busy_q, result_valid_q, frame_err_q;
   logic [bit_cnt-1:0] result_q;
   logic [7:0]         cur_byte;
   logic [BW-1:0]      rx_tgt;

   // Challenge goes out MSB byte first: the current byte always sits at the top.
   assign cur_byte = chal_q[CHW-1 -: 8];
   // First receive interval lands mid start bit; the rest are whole bit times.
   assign rx_tgt   = (bit_q == 4'd0) ? BW'(BAUD_DIV / 2 - 1) : BW'(BAUD_DIV - 1);

`ifdef RESP_TIMEOUT_EN
   localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
   logic [WDW-1:0] wd_q;
   logic           timeout_q;
   assign timeout = timeout_q;
`else
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q        <= IDLE;
         chal_q         <= '0;
         baud_q         <= '0;
         bit_q          <= '0;
         tx_byte_q      <= '0;
         rx_byte_q      <= '0;
         shreg_q        <= '0;
         acc_q          <= '0;
         rx_s1_q        <= 1'b1;
         rx_s2_q        <= 1'b1;
         rx_prev_q      <= 1'b1;
         tx_q           <= 1'b1;
         busy_q         <= 1'b0;
         result_q       <= '0;
         result_valid_q <= 1'b0;
         frame_err_q    <= 1'b0;
`ifdef RESP_TIMEOUT_EN
         wd_q           <= '0;
         timeout_q      <= 1'b0;
`endif
      end else begin
         rx_s1_q        <= rx;
         rx_s2_q        <= rx_s1_q;
         rx_prev_q      <= rx_s2_q;
         result_valid_q <= 1'b0;
         frame_err_q    <= 1'b0;
`ifdef RESP_TIMEOUT_EN
         timeout_q      <= 1'b0;
`endif
         case (state_q)
            IDLE: begin
               if (start) begin
                  chal_q    <= CHW'(challenge);
                  state_q   <= TX_CHAL;
                  busy_q    <= 1'b1;
                  tx_q      <= 1'b0;
                  baud_q    <= '0;
                  bit_q     <= '0;
                  tx_byte_q <= '0;
               end
            end
            TX_CHAL: begin
               if (baud_q == BW'(BAUD_DIV - 1)) begin
                  baud_q <= '0;
                  if (bit_q == 4'd9) begin
                     if (tx_byte_q == CBW'(CB_BYTES - 1)) begin
                        state_q   <= WAIT_RESP;
                        rx_byte_q <= '0;
                        acc_q     <= '0;
`ifdef RESP_TIMEOUT_EN
                        wd_q      <= '0;
`endif
                     end else begin
                        // Next byte's start bit follows the stop bit with no gap.
                        tx_byte_q <= tx_byte_q + CBW'(1);
                        chal_q    <= chal_q << 8;
                        bit_q     <= '0;
                        tx_q      <= 1'b0;
                     end
                  end else begin
                     bit_q <= bit_q + 4'd1;
                     tx_q  <= (bit_q == 4'd8) ? 1'b1 : cur_byte[bit_q[2:0]];
                  end
               end else begin
                  baud_q <= baud_q + BW'(1);
               end
            end
            WAIT_RESP: begin
               if (rx_prev_q && !rx_s2_q) begin
                  state_q <= RX_BYTE;
                  baud_q  <= '0;
                  bit_q   <= '0;
               end
`ifdef RESP_TIMEOUT_EN
               else if (wd_q == WDW'(TIMEOUT_CYCLES - 1)) begin
                  timeout_q <= 1'b1;
                  busy_q    <= 1'b0;
                  state_q   <= IDLE;
               end else begin
                  wd_q <= wd_q + WDW'(1);
               end
`endif
            end
            RX_BYTE: begin
               if (baud_q == rx_tgt) begin
                  baud_q <= '0;
                  bit_q  <= bit_q + 4'd1;
                  if (bit_q == 4'd0) begin
                     // Start bit gone high again by mid-bit: it was a glitch.
                     if (rx_s2_q) state_q <= WAIT_RESP;
                  end else if (bit_q == 4'd9) begin
                     if (!rx_s2_q) begin
                        frame_err_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                     end else if (rx_byte_q == RBW'(RB_BYTES - 1)) begin
                        // Truncating cast drops the upper padding of the top byte.
                        result_q       <= bit_cnt'({acc_q, shreg_q});
                        result_valid_q <= 1'b1;
                        busy_q         <= 1'b0;
                        state_q        <= IDLE;
                     end else begin
                        acc_q     <= bit_cnt'({acc_q, shreg_q});
                        rx_byte_q <= rx_byte_q + RBW'(1);
                        state_q   <= WAIT_RESP;
`ifdef RESP_TIMEOUT_EN
                        wd_q      <= '0;
`endif
                     end
                  end else begin
                     shreg_q <= {rx_s2_q, shreg_q[7:1]};
                  end
               end else begin
                  baud_q <= baud_q + BW'(1);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign tx           = tx_q;
   assign busy         = busy_q;
   assign result       = result_q;
   assign result_valid = result_valid_q;
   assign frame_err    = frame_err_q;

endmodule

// File: tb/tb_uart_challenge_host.sv
// Bench for uart_challenge_host: random challenges/responses against a byte-level reference model.
// Expected pulses (kind, cycle, result) are queued by the stimulus and popped by an output monitor.
// Runs at BAUD_DIV=16 with TIMEOUT_CYCLES=1000.
module tb_uart_challenge_host;
   localparam int BD = 16;
   localparam int TO = 1000;

   typedef logic [7:0] resp_t [4];
   typedef struct {
      logic [2:0]  kind;   // {timeout, frame_err, result_valid}
      int          at;
      logic [28:0] res;
   } ev_t;

   logic        clk = 1'b0, rst = 1'b0, start = 1'b0, rx = 1'b1;
   logic [7:0]  challenge = 8'h00;
   logic        busy, tx, result_valid, frame_err, timeout;
   logic [28:0] result;

   int          cyc = 0;
   int          passed = 0, total = 0;
   ev_t         exp_q[$];
   logic [28:0] model_res = '0;

   uart_challenge_host #(
      .frequency_clk_ref(1), .baud_rate(62500), .Challenge_Bit(8),
      .bit_cnt(29), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .challenge(challenge), .busy(busy),
      .tx(tx), .rx(rx), .result(result), .result_valid(result_valid),
      .frame_err(frame_err), .timeout(timeout)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
      else passed++;
   endtask

   // Reference: response is the big-endian concatenation of the bytes, low 29 bits kept.
   function automatic logic [28:0] model_result(input resp_t b);
      longint v = 0;
      for (int i = 0; i < 4; i++) v = v * 256 + longint'(b[i]);
      return 29'(v % (longint'(1) << 29));
   endfunction

   // Reference: 8N1 frame bit k of a challenge byte.
   function automatic logic frame_bit(input logic [7:0] ch, input int k);
      if (k == 0) return 1'b0;
      if (k == 9) return 1'b1;
      return 1'(( int'(ch) >> (k - 1)) % 2);
   endfunction

   // Output monitor / scoreboard.
   logic [2:0] prev_p = 3'b000;
   always @(negedge clk) begin
      logic [2:0] p;
      ev_t        e;
      p = {timeout, frame_err, result_valid};
      if (prev_p != 3'b000) chk("pulse_width", 64'(p), 64'(0));
      if (p != 3'b000) begin
         if (exp_q.size() == 0) chk("unexpected_pulse", 64'(p), 64'(0));
         else begin
            e = exp_q.pop_front();
            chk("pulse_kind", 64'(p), 64'(e.kind));
            chk("pulse_cycle", 64'(cyc), 64'(e.at));
            chk("result_at_pulse", 64'(result), 64'(e.res));
            chk("busy_at_pulse", 64'(busy), 64'(0));
         end
      end
      prev_p = p;
   end

   task automatic wait_drain(input int budget);
      int k = 0;
      while (exp_q.size() != 0 && k < budget) begin
         @(negedge clk);
         k++;
      end
      chk("events_drained", 64'(exp_q.size()), 64'(0));
   endtask

   task automatic do_reset(input int n);
      rst = 1'b0;
      repeat (n) @(negedge clk);
      chk("rst_tx", 64'(tx), 64'(1));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_result", 64'(result), 64'(0));
      chk("rst_pulses", 64'({timeout, frame_err, result_valid}), 64'(0));
      model_res = '0;
      rst = 1'b1;
      @(negedge clk);
   endtask

   // Issues start and checks every bit boundary of the challenge frame.
   task automatic send_challenge(input logic [7:0] ch);
      chk("tx_idle_before_start", 64'(tx), 64'(1));
      start = 1'b1;
      challenge = ch;
      @(negedge clk);
      start = 1'b0;
      challenge = 8'($urandom);
      for (int n = 0; n < 10 * BD; n++) begin
         if (n % BD == 0 || n % BD == BD - 1)
            chk($sformatf("tx_bit%0d", n / BD), 64'(tx), 64'(frame_bit(ch, n / BD)));
         if (n % BD == 0) chk("busy_during_tx", 64'(busy), 64'(1));
         @(negedge clk);
      end
      chk("tx_idle_after_frame", 64'(tx), 64'(1));
      chk("busy_wait_resp", 64'(busy), 64'(1));
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      rx = 1'b0;
      repeat (BD) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (BD) @(negedge clk);
      end
      rx = stop_bit;
      repeat (BD) @(negedge clk);
      rx = 1'b1;
   endtask

   // Stop sample = pin edge + 2 sync + BD/2 + 9*BD; pulse shows one cycle later.
   task automatic send_resp(input resp_t b, input int bad);
      ev_t e;
      for (int i = 0; i < 4; i++) begin
         if (i == bad) begin
            e.kind = 3'b010; e.at = cyc + 1 + 2 + BD / 2 + 9 * BD; e.res = model_res;
            exp_q.push_back(e);
            send_byte(b[i], 1'b0);
         end else if (i == 3 && (bad < 0 || bad > 3)) begin
            model_res = model_result(b);
            e.kind = 3'b001; e.at = cyc + 1 + 2 + BD / 2 + 9 * BD; e.res = model_res;
            exp_q.push_back(e);
            send_byte(b[i], 1'b1);
         end else begin
            send_byte(b[i], 1'b1);
         end
      end
      repeat (4) @(negedge clk);
      wait_drain(400);
   endtask

   initial begin
      #(10 * 60000);
      $display("FAIL global_timeout cycle=%0d required=finish", cyc);
      $fatal(1, "bench timed out");
   end

   initial begin
      resp_t r;
      ev_t   e;
      int    bad;

      // Reset: 3 cycles low.
      repeat (3) @(negedge clk);
      chk("reset_tx", 64'(tx), 64'(1));
      chk("reset_busy", 64'(busy), 64'(0));
      rst = 1'b1;
      @(negedge clk);
      chk("post_reset_tx", 64'(tx), 64'(1));
      chk("post_reset_busy", 64'(busy), 64'(0));
      chk("post_reset_result", 64'(result), 64'(0));
      chk("post_reset_pulses", 64'({timeout, frame_err, result_valid}), 64'(0));

      // Directed: A5 challenge, response 1F FF 00 42.
      send_challenge(8'hA5);
      r = '{8'h1F, 8'hFF, 8'h00, 8'h42};
      send_resp(r, -1);
      chk("directed_result", 64'(result), 64'(29'h1FFF0042));

      // Bad stop bit on the second byte; remaining bytes arrive while idle.
      send_challenge(8'h3C);
      r = '{8'h12, 8'h34, 8'h56, 8'h78};
      send_resp(r, 1);
      chk("frame_err_result_held", 64'(result), 64'(29'h1FFF0042));
      chk("frame_err_busy", 64'(busy), 64'(0));

      // Start glitch in WAIT_RESP, plus a start while busy that must be dropped.
      send_challenge(8'($urandom));
      repeat (20) @(negedge clk);
      rx = 1'b0;
      repeat (4) @(negedge clk);
      rx = 1'b1;
      repeat (40) @(negedge clk);
      chk("glitch_busy", 64'(busy), 64'(1));
      start = 1'b1; challenge = 8'($urandom);
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      chk("start_while_busy_tx", 64'(tx), 64'(1));
      for (int i = 0; i < 4; i++) r[i] = 8'($urandom);
      send_resp(r, -1);

      // Random transactions, some with a bad stop bit.
      for (int t = 0; t < 6; t++) begin
         send_challenge(8'($urandom));
         for (int i = 0; i < 4; i++) r[i] = 8'($urandom);
         bad = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 3)) : -1;
         send_resp(r, bad);
      end

      // Reset during data bit 3 (frame bit 4), then a normal transaction.
      start = 1'b1; challenge = 8'($urandom);
      @(negedge clk);
      start = 1'b0;
      repeat (4 * BD + 6) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("midtx_rst_tx", 64'(tx), 64'(1));
      chk("midtx_rst_busy", 64'(busy), 64'(0));
      chk("midtx_rst_result", 64'(result), 64'(0));
      model_res = '0;
      rst = 1'b1;
      @(negedge clk);
      send_challenge(8'($urandom));
      for (int i = 0; i < 4; i++) r[i] = 8'($urandom);
      send_resp(r, -1);

      // No response at all.
      send_challenge(8'($urandom));
`ifdef RESP_TIMEOUT_EN
      e.kind = 3'b100; e.at = cyc + TO; e.res = model_res;
      exp_q.push_back(e);
      wait_drain(TO + 200);
      @(negedge clk);
      chk("timeout_busy", 64'(busy), 64'(0));
`else
      repeat (5000) @(negedge clk);
      chk("no_watchdog_busy", 64'(busy), 64'(1));
      chk("no_watchdog_tx", 64'(tx), 64'(1));
      do_reset(3);
`endif

      repeat (5) @(negedge clk);
      chk("final_queue_empty", 64'(exp_q.size()), 64'(0));
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/uart_challenge_host.md
# uart_challenge_host

Host-side end of the challenge/response UART link. Serialises a `Challenge_Bit`-wide challenge onto `tx` as 8N1 bytes and then deserialises the `bit_cnt`-wide frequency-count response arriving on `rx`. The block sits opposite the measurement top-level, either in a bench harness or in a controller FPGA. It provides a single start/result handshake to local logic.

## Interface
- `frequency_clk_ref`, 100: `clk` frequency in MHz.
- `baud_rate`, 115200: line rate; derived `BAUD_DIV = frequency_clk_ref*1000000/baud_rate` (868 at defaults, must be ≥ 4).
- `Challenge_Bit`, 8: challenge width; `CB_BYTES = ceil(Challenge_Bit/8)`.
- `bit_cnt`, 29: response width; `RB_BYTES = ceil(bit_cnt/8)` (4 at default).
- `TIMEOUT_CYCLES`, 10000000: response watchdog limit in `clk` cycles.

Ports:
- `clk` in 1: single clock; everything is synchronous to it.
- `rst` in 1: synchronous, active-low reset.
- `start` in 1: one-cycle request; sampled only while idle.
- `challenge` in `Challenge_Bit`: captured on the accepted `start`.
- `busy` out 1: high from the cycle after an accepted `start` until return to IDLE.
- `tx` out 1: serial out, idle high.
- `rx` in 1: serial in, asynchronous to `clk`.
- `result` out `bit_cnt`: last good response; held until the next `result_valid`.
- `result_valid` out 1: one-cycle pulse.
- `frame_err` out 1: one-cycle pulse.
- `timeout` out 1: one-cycle pulse.

## Operation
- Reset values: `tx`=1, `busy`=0, `result`=0, and all pulse outputs 0. Internal counters, the FSM and both synchroniser flops (loaded with 1) are also cleared.
- `rx` passes through a 2-flop synchroniser before any use.
- FSM states:
  - IDLE: on `start`, capture `challenge` (zero-extended to `8*CB_BYTES` bits) and go to TX_CHAL.
  - TX_CHAL: send `CB_BYTES` bytes, most-significant byte first, each as start(0), 8 data bits LSB first, stop(1). Then go to WAIT_RESP.
  - WAIT_RESP: wait for a falling edge on the synchronised `rx`, then go to RX_BYTE.
  - RX_BYTE: receive one byte and shift it into the result accumulator, MSB byte first. After `RB_BYTES` bytes, go to DONE; otherwise return to WAIT_RESP.
  - DONE: load `result` with the low `bit_cnt` bits of the accumulator (upper padding discarded), pulse `result_valid`, go to IDLE.
- Receive sampling:
  - The start bit is re-sampled at `BAUD_DIV/2` cycles after the falling edge. If it reads high, treat it as a glitch and return to WAIT_RESP.
  - Data bits are sampled every `BAUD_DIV` cycles after that.
  - The stop bit is sampled one further `BAUD_DIV` later. If it reads 0, pulse `frame_err`, discard the partial response and go to IDLE.
- `rx` activity during IDLE or TX_CHAL is ignored.
- `start` asserted while `busy` is dropped; there is no queueing.

## Timing
- The `tx` start bit begins the cycle after `start` is accepted.
- Each bit occupies exactly `BAUD_DIV` cycles.
- TX_CHAL lasts `10*BAUD_DIV*CB_BYTES` cycles. Consecutive challenge bytes go back-to-back with no idle gap.
- `result_valid` is asserted exactly 1 cycle after the final stop-bit sample. `busy` falls in that same cycle.
- `frame_err` is asserted 1 cycle after the bad stop-bit sample. `busy` falls in that same cycle.
- Synchroniser latency: 2 cycles from the `rx` pin to the falling-edge detector.
- Reset mid-operation: the next edge restores all reset values, and `tx` is high one cycle after `rst` is sampled low. No partial pulses are emitted.

## Configuration
- `RESP_TIMEOUT_EN` defined:
  - A watchdog counts cycles spent in WAIT_RESP. It is cleared on entry to WAIT_RESP, both from TX_CHAL and after each completed byte.
  - On reaching `TIMEOUT_CYCLES`, the block pulses `timeout`, drops `busy` and returns to IDLE.
- `RESP_TIMEOUT_EN` undefined:
  - There is no watchdog, and `timeout` is tied to 0.
  - WAIT_RESP waits indefinitely; only reset recovers the block.

## Test plan
The bench uses `frequency_clk_ref`=1, `baud_rate`=62500 (`BAUD_DIV`=16), `Challenge_Bit`=8, `bit_cnt`=29.
- Reset: hold `rst`=0 for 3 cycles, then release. Required: `tx`=1, `busy`=0, `result`=0, and no pulses.
- Challenge transmit: `challenge`=8'hA5, `start` pulse. Required: `tx` sequence 0,1,0,1,0,0,1,0,1,1, each bit lasting 16 cycles and starting 1 cycle after `start`. `busy` stays high.
- Good response: after the challenge, the bench model sends bytes 1F FF 00 42. Required: `result`=29'h1FFF0042, a single-cycle `result_valid` 1 cycle after the last stop sample, and `frame_err`=0.
- Bad stop bit: the second response byte is sent with stop=0. Required: a `frame_err` pulse, no `result_valid`, `result` unchanged, and `busy`=0.
- Timeout: `RESP_TIMEOUT_EN` defined, `TIMEOUT_CYCLES`=1000, no response. Required: a `timeout` pulse exactly 1000 cycles after the challenge stop bit ends, then `busy`=0. With the macro undefined, `busy` must still be 1 after 5000 cycles.
- Reset mid-TX and start glitch:
  - Drop `rst` during data bit 3. Required: `tx`=1 and `busy`=0 on the next edge. A `start` issued right after release transmits normally.
  - A 4-cycle low glitch on `rx` in WAIT_RESP must be rejected.
